// File: rtl/vend_slot_arbiter.sv
// Two-slot front-panel arbiter for a single vending core: grants one slot per
// purchase session round-robin, forwards coins, tracks credit, serves, refunds and aborts.
module vend_slot_arbiter #(
   parameter int PRICE       = 15,
   parameter int CREDIT_W    = 5,
   parameter int TIMEOUT_CYC = 16,
   parameter int VEND_WAIT   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin_a,
   input  logic [1:0]          coin_b,
   output logic                ack_a,
   output logic                ack_b,
   output logic [1:0]          core_coin,
   output logic                core_clr,
   input  logic                core_coke,
   output logic                sess_active,
   output logic                owner,
   output logic                serve_a,
   output logic                serve_b,
   output logic                refund_a,
   output logic                refund_b,
   output logic [CREDIT_W-1:0] refund_amt,
   output logic                vend_err
);

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int VW_W  = (VEND_WAIT > 1) ? $clog2(VEND_WAIT) : 1;

   localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
   localparam logic [TMR_W-1:0]    IDLE_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [VW_W-1:0]     VEND_LAST = VW_W'(VEND_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OWN,
      S_WAIT_VEND,
      S_DONE,
      S_ABORT
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                owner_q, owner_d;
   logic                rr_q, rr_d;
   logic [TMR_W-1:0]    idle_tmr_q, idle_tmr_d;
   logic [VW_W-1:0]     vend_tmr_q, vend_tmr_d;
   logic                sess_q, sess_d;
   logic                ack_a_q, ack_a_d;
   logic                ack_b_q, ack_b_d;
   logic [1:0]          core_coin_q, core_coin_d;
   logic                core_clr_q, core_clr_d;
   logic                serve_a_q, serve_a_d;
   logic                serve_b_q, serve_b_d;
   logic                refund_a_q, refund_a_d;
   logic                refund_b_q, refund_b_d;
   logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
   logic                vend_err_q, vend_err_d;

   logic                req_a, req_b;
   logic                take_a, take_b, take;
   logic [1:0]          take_code;
   logic [CREDIT_W:0]   coin_val;
   logic [CREDIT_W:0]   credit_sum;
   logic [CREDIT_W-1:0] credit_acc;

   // A slot whose ack is still high is not re-sampled, limiting it to one coin per two cycles.
   assign req_a = (coin_a != 2'b00) && !ack_a_q;
   assign req_b = (coin_b != 2'b00) && !ack_b_q;

   always_comb begin
      take_a = 1'b0;
      take_b = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_a && req_b) begin
               take_a = !rr_q;
               take_b = rr_q;
            end else begin
               take_a = req_a;
               take_b = req_b;
            end
         end
         S_OWN: begin
            take_a = req_a && !owner_q;
            take_b = req_b && owner_q;
         end
         default: begin
            take_a = 1'b0;
            take_b = 1'b0;
         end
      endcase
   end

   assign take      = take_a || take_b;
   assign take_code = take_b ? coin_b : coin_a;

   always_comb begin
      case (take_code)
         2'b01:   coin_val = (CREDIT_W+1)'(5);
         2'b11:   coin_val = (CREDIT_W+1)'(10);
         default: coin_val = '0;
      endcase
   end

   assign credit_sum = {1'b0, credit_q} + coin_val;
   assign credit_acc = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      owner_d      = owner_q;
      rr_d         = rr_q;
      idle_tmr_d   = idle_tmr_q;
      vend_tmr_d   = vend_tmr_q;
      sess_d       = sess_q;
      vend_err_d   = vend_err_q;
      ack_a_d      = take_a;
      ack_b_d      = take_b;
      core_coin_d  = (take && take_code != 2'b10) ? take_code : 2'b00;
      core_clr_d   = 1'b0;
      serve_a_d    = 1'b0;
      serve_b_d    = 1'b0;
      refund_a_d   = 1'b0;
      refund_b_d   = 1'b0;
      refund_amt_d = '0;

      // A coke pulse is only meaningful while a vend is awaited; anywhere else it flags a core fault.
      if (core_coke && state_q != S_WAIT_VEND) begin
         vend_err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (take) begin
               owner_d    = take_b;
               sess_d     = 1'b1;
               credit_d   = credit_acc;
               idle_tmr_d = '0;
               vend_tmr_d = '0;
               state_d    = (credit_acc >= PRICE_C) ? S_WAIT_VEND : S_OWN;
            end
         end
         S_OWN: begin
            if (take) begin
               credit_d   = credit_acc;
               idle_tmr_d = '0;
               vend_tmr_d = '0;
               if (credit_acc >= PRICE_C) begin
                  state_d = S_WAIT_VEND;
               end
            end else if (idle_tmr_q == IDLE_LAST) begin
               state_d      = S_ABORT;
               core_clr_d   = 1'b1;
               refund_a_d   = (credit_q != '0) && !owner_q;
               refund_b_d   = (credit_q != '0) && owner_q;
               refund_amt_d = credit_q;
            end else begin
               idle_tmr_d = idle_tmr_q + 1'b1;
            end
         end
         S_WAIT_VEND: begin
            if (core_coke) begin
               state_d   = S_DONE;
               serve_a_d = !owner_q;
               serve_b_d = owner_q;
               if (credit_q > PRICE_C) begin
                  refund_a_d   = !owner_q;
                  refund_b_d   = owner_q;
                  refund_amt_d = credit_q - PRICE_C;
               end
            end else if (vend_tmr_q == VEND_LAST) begin
               state_d      = S_ABORT;
               vend_err_d   = 1'b1;
               core_clr_d   = 1'b1;
               refund_a_d   = (credit_q != '0) && !owner_q;
               refund_b_d   = (credit_q != '0) && owner_q;
               refund_amt_d = credit_q;
            end else begin
               vend_tmr_d = vend_tmr_q + 1'b1;
            end
         end
         S_DONE, S_ABORT: begin
            // Hand priority to the other slot so a busy slot cannot starve its neighbour.
            state_d  = S_IDLE;
            credit_d = '0;
            rr_d     = !owner_q;
            sess_d   = 1'b0;
         end
         default: begin
            state_d  = S_IDLE;
            credit_d = '0;
            sess_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         owner_q      <= 1'b0;
         rr_q         <= 1'b0;
         idle_tmr_q   <= '0;
         vend_tmr_q   <= '0;
         sess_q       <= 1'b0;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         core_coin_q  <= 2'b00;
         core_clr_q   <= 1'b0;
         serve_a_q    <= 1'b0;
         serve_b_q    <= 1'b0;
         refund_a_q   <= 1'b0;
         refund_b_q   <= 1'b0;
         refund_amt_q <= '0;
         vend_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         owner_q      <= owner_d;
         rr_q         <= rr_d;
         idle_tmr_q   <= idle_tmr_d;
         vend_tmr_q   <= vend_tmr_d;
         sess_q       <= sess_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         core_coin_q  <= core_coin_d;
         core_clr_q   <= core_clr_d;
         serve_a_q    <= serve_a_d;
         serve_b_q    <= serve_b_d;
         refund_a_q   <= refund_a_d;
         refund_b_q   <= refund_b_d;
         refund_amt_q <= refund_amt_d;
         vend_err_q   <= vend_err_d;
      end
   end

   assign ack_a       = ack_a_q;
   assign ack_b       = ack_b_q;
   assign core_coin   = core_coin_q;
   assign core_clr    = core_clr_q;
   assign sess_active = sess_q;
   assign owner       = owner_q;
   assign serve_a     = serve_a_q;
   assign serve_b     = serve_b_q;
   assign refund_a    = refund_a_q;
   assign refund_b    = refund_b_q;
   assign refund_amt  = refund_amt_q;
   assign vend_err    = vend_err_q;

endmodule
